clk_mon: RTL and testbench

- Receive-side companion to the counter-based clock divider: it takes a divided clock and recovers the divider setting from it.
- Samples the divided clock on fsys, measures the rising-edge-to-rising-edge period in fsys cycles, and decodes the power-of-two scale index that produced it.
- Reports loss-of-clock (timeout) and frequency lock (two consecutive equal periods).
- Used for self-check and bring-up of divided clock domains.

---
 rtl/clk_pkg.sv | 42 ++++
 rtl/clk_sync.sv | 29 ++
 rtl/clk_mon.sv | 140 ++++++++++++++
 tb/tb_clk_mon.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_pkg.sv
// Shared types and helpers for divided-clock monitors: FSM states and the
// power-of-two period-to-scale decoder.
package clk_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int SC_MAX_PW       = 33;
  localparam int SC_IDX_W        = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } state_e;

  typedef struct packed {
    logic                ok;
    logic [SC_IDX_W-1:0] idx;
  } sc_dec_t;

  // A legal period has exactly one bit set at position 1..size; the index is position-1.
  function automatic sc_dec_t sc_decode(input logic [SC_MAX_PW-1:0] period, input int size);
    sc_dec_t res;
    int      ones;
    res.ok  = 1'b0;
    res.idx = '0;
    ones    = 0;
    for (int p = 0; p < SC_MAX_PW; p++) begin
      if (period[p]) begin
        ones = ones + 32'sd1;
        if ((p >= 32'sd1) && (p <= size)) begin
          res.ok  = 1'b1;
          res.idx = SC_IDX_W'(p - 32'sd1);
        end
      end
    end
    if (ones != 32'sd1) begin
      res.ok = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/clk_sync.sv
// N-flop level synchronizer with synchronous active-high reset; reusable by
// any consumer of a divided clock.
module clk_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] stage_q;
  logic [N-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[N-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[N-1];

endmodule

// File: rtl/clk_mon.sv
// Measures the rise-to-rise period of a divided clock in fsys cycles, decodes
// the divider scale, and flags lock and loss-of-clock. SIZE must be 2..32.
module clk_mon
  import clk_pkg::*;
#(
  parameter int SIZE        = 8,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                    fsys,
  input  logic                    clk_mon_rst,
  input  logic                    clk_mon_in,
  output logic [SIZE:0]           clk_mon_period,
  output logic                    clk_mon_valid,
  output logic [$clog2(SIZE)-1:0] clk_mon_sc,
  output logic                    clk_mon_sc_ok,
  output logic                    clk_mon_locked,
  output logic                    clk_mon_timeout
);

  localparam int            SC_W    = $clog2(SIZE);
  localparam logic [SIZE:0] CNT_MAX = '1;
  localparam logic [SIZE:0] CNT_ONE = {{SIZE{1'b0}}, 1'b1};

  logic            sync_s;
  logic            rise_s;
  logic            sc_fit_s;
  sc_dec_t         dec_s;
  logic            in_prev_q, in_prev_d;
  logic [SIZE:0]   cnt_q, cnt_d;
  logic [SIZE:0]   period_q, period_d;
  logic [SIZE:0]   prev_period_q, prev_period_d;
  logic [SC_W-1:0] sc_q, sc_d;
  state_e          state_q, state_d;
  logic            valid_q, valid_d;
  logic            sc_ok_q, sc_ok_d;
  logic            locked_q, locked_d;
  logic            timeout_q, timeout_d;

  clk_sync #(.N(SYNC_STAGES)) u_sync (
    .clk (fsys),
    .rst (clk_mon_rst),
    .d   (clk_mon_in),
    .q   (sync_s)
  );

  // Edge detect, saturating period counter and scale decode of the running count.
  always_comb begin
    in_prev_d = sync_s;
    rise_s    = sync_s & ~in_prev_q;
    if (rise_s) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
    dec_s    = sc_decode(SC_MAX_PW'(cnt_q), SIZE);
    sc_fit_s = ((dec_s.idx >> SC_W) == SC_IDX_W'(0));
  end

  // Measurement FSM; a rise always beats a coincident timeout.
  always_comb begin
    state_d       = state_q;
    period_d      = period_q;
    prev_period_d = prev_period_q;
    valid_d       = 1'b0;
    sc_d          = sc_q;
    sc_ok_d       = sc_ok_q;
    locked_d      = locked_q;
    timeout_d     = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (rise_s) begin
          state_d = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM, ST_MEAS: begin
        if (rise_s) begin
          period_d      = cnt_q;
          prev_period_d = cnt_q;
          valid_d       = 1'b1;
          timeout_d     = 1'b0;
          locked_d      = (state_q == ST_MEAS) && (cnt_q == prev_period_q);
          state_d       = ST_MEAS;
          if (dec_s.ok && sc_fit_s) begin
            sc_d    = dec_s.idx[SC_W-1:0];
            sc_ok_d = 1'b1;
          end else begin
            sc_ok_d = 1'b0;
          end
        end else if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge fsys) begin
    if (clk_mon_rst) begin
      in_prev_q     <= 1'b0;
      cnt_q         <= '0;
      state_q       <= ST_IDLE;
      period_q      <= '0;
      prev_period_q <= '0;
      valid_q       <= 1'b0;
      sc_q          <= '0;
      sc_ok_q       <= 1'b0;
      locked_q      <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      in_prev_q     <= in_prev_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      period_q      <= period_d;
      prev_period_q <= prev_period_d;
      valid_q       <= valid_d;
      sc_q          <= sc_d;
      sc_ok_q       <= sc_ok_d;
      locked_q      <= locked_d;
      timeout_q     <= timeout_d;
    end
  end

  assign clk_mon_period  = period_q;
  assign clk_mon_valid   = valid_q;
  assign clk_mon_sc      = sc_q;
  assign clk_mon_sc_ok   = sc_ok_q;
  assign clk_mon_locked  = locked_q;
  assign clk_mon_timeout = timeout_q;

endmodule

// File: tb/tb_clk_mon.sv
// Randomized bench for clk_mon: a rise-time based reference model predicts every
// output each cycle, delayed by the fixed input-to-output latency.
module tb_clk_mon;

  localparam int SIZE = 8;
  localparam int NS   = 2;
  localparam int LAT  = NS + 1;
  localparam int TMO  = (1 << (SIZE + 1)) - 1;

  logic                    fsys = 1'b0;
  logic                    clk_mon_rst;
  logic                    clk_mon_in;
  logic [SIZE:0]           clk_mon_period;
  logic                    clk_mon_valid;
  logic [$clog2(SIZE)-1:0] clk_mon_sc;
  logic                    clk_mon_sc_ok;
  logic                    clk_mon_locked;
  logic                    clk_mon_timeout;

  always #5 fsys = ~fsys;

  clk_mon #(.SIZE(SIZE), .SYNC_STAGES(NS)) dut (
    .fsys            (fsys),
    .clk_mon_rst     (clk_mon_rst),
    .clk_mon_in      (clk_mon_in),
    .clk_mon_period  (clk_mon_period),
    .clk_mon_valid   (clk_mon_valid),
    .clk_mon_sc      (clk_mon_sc),
    .clk_mon_sc_ok   (clk_mon_sc_ok),
    .clk_mon_locked  (clk_mon_locked),
    .clk_mon_timeout (clk_mon_timeout)
  );

  typedef struct {
    int period;
    int valid;
    int sc;
    int sc_ok;
    int locked;
    int timeout;
  } exp_t;

  exp_t pipe[$];
  exp_t m_out;
  int   m_phase;   // 0 idle, 1 armed, 2 measuring
  int   m_gap;
  int   m_prev_p;
  int   m_prev_v;
  int   div_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e.period = 0; e.valid = 0; e.sc = 0; e.sc_ok = 0; e.locked = 0; e.timeout = 0;
    return e;
  endfunction

  function automatic void model_reset();
    m_phase  = 0;
    m_gap    = 0;
    m_prev_p = 0;
    m_prev_v = 0;
    m_out    = zero_exp();
  endfunction

  function automatic int log2_exact(input int p);
    for (int j = 0; j < 31; j++) begin
      if (p == (1 << j)) return j;
    end
    return -1;
  endfunction

  // One input cycle of the reference: periods are gaps between observed rises.
  function automatic void model_step(input int v);
    int rise;
    int j;
    rise      = (v == 1 && m_prev_v == 0) ? 1 : 0;
    m_prev_v  = v;
    m_gap     = m_gap + 1;
    m_out.valid = 0;
    if (m_phase == 0) begin
      if (rise == 1) begin
        m_phase = 1;
        m_gap   = 0;
      end
    end else if (rise == 1) begin
      j = log2_exact(m_gap);
      m_out.period = m_gap;
      m_out.valid  = 1;
      if (j >= 1 && j <= SIZE) begin
        m_out.sc    = j - 1;
        m_out.sc_ok = 1;
      end else begin
        m_out.sc_ok = 0;
      end
      m_out.locked  = (m_phase == 2 && m_gap == m_prev_p) ? 1 : 0;
      m_out.timeout = 0;
      m_prev_p      = m_gap;
      m_phase       = 2;
      m_gap         = 0;
    end else if (m_gap == TMO) begin
      m_out.timeout = 1;
      m_out.locked  = 0;
      m_phase       = 0;
    end
  endfunction

  task automatic step(input logic v, input logic r);
    exp_t e;
    @(posedge fsys);
    #1;
    e = pipe.pop_front();
    check_val("period",  32'(clk_mon_period),  e.period);
    check_val("valid",   32'(clk_mon_valid),   e.valid);
    check_val("sc",      32'(clk_mon_sc),      e.sc);
    check_val("sc_ok",   32'(clk_mon_sc_ok),   e.sc_ok);
    check_val("locked",  32'(clk_mon_locked),  e.locked);
    check_val("timeout", 32'(clk_mon_timeout), e.timeout);
    clk_mon_rst = r;
    clk_mon_in  = v;
    div_cnt     = div_cnt + 1;
    if (r) begin
      model_reset();
      foreach (pipe[i]) pipe[i] = zero_exp();
    end else begin
      model_step(int'(v));
    end
    pipe.push_back(m_out);
  endtask

  task automatic run_div(input int k, input int n);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d = div_cnt;
      step(d[k], 1'b0);
    end
  endtask

  task automatic run_const(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v, 1'b0);
  endtask

  task automatic run_pulse(input int p, input int n);
    for (int i = 0; i < n; i++) step((i % p) == 0, 1'b0);
  endtask

  task automatic run_rand(input int n);
    for (int i = 0; i < n; i++) step(1'($urandom), 1'b0);
  endtask

  task automatic do_reset(input int k, input int n);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d = div_cnt;
      step(d[k], 1'b1);
    end
  endtask

  initial begin
    clk_mon_rst = 1'b1;
    clk_mon_in  = 1'b0;
    model_reset();
    for (int i = 0; i < LAT; i++) pipe.push_back(zero_exp());
    do_reset(0, 4);
    run_div(0, 40);
    run_div(3, 200);
    run_div(7, 1400);
    run_div(2, 100);
    run_const(1'b0, 700);
    run_div(2, 100);
    run_div(4, 300);
    run_div(6, 420);
    do_reset(6, 2);
    run_div(6, 600);
    run_pulse(511, 1600);
    run_pulse(512, 1700);
    run_pulse(256, 800);
    run_pulse(3, 30);
    run_const(1'b1, 600);
    run_pulse(2, 20);
    for (int it = 0; it < 14; it++) begin
      case ($urandom_range(0, 4))
        0: run_div(int'($urandom_range(0, SIZE - 1)), int'($urandom_range(50, 700)));
        1: run_rand(int'($urandom_range(20, 80)));
        2: run_const(1'b0, int'($urandom_range(300, 700)));
        3: run_pulse(int'($urandom_range(2, 520)), int'($urandom_range(200, 1200)));
        default: do_reset(int'($urandom_range(0, SIZE - 1)), int'($urandom_range(1, 4)));
      endcase
    end
    run_div(1, 40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
